// File: rtl/layer_argmax_collector_if.sv
// rtl/layer_argmax_collector_if.sv - result handshake bundle between the argmax collector and its consumer
interface layer_argmax_collector_if #(
    parameter int DW   = 8,
    parameter int IDXW = 4
);
    logic            res_valid;
    logic            res_ready;
    logic [IDXW-1:0] res_idx;
    logic [DW-1:0]   res_val;
    logic            res_tie;

    modport master (output res_valid, output res_idx, output res_val, output res_tie, input res_ready);
    modport slave  (input res_valid, input res_idx, input res_val, input res_tie, output res_ready);
endinterface

// File: rtl/layer_argmax_collector.sv
// rtl/layer_argmax_collector.sv - snapshots final-layer neuron outputs and scans them for the winning class
module layer_argmax_collector #(
    parameter int NUM_IN = 8,
    parameter int DW     = 8,
    parameter int IDXW   = 4,
    parameter int LAT    = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   src_valid_i,
    input  logic [NUM_IN*DW-1:0]   node_out_i,
    output logic                   busy_o,
    output logic [7:0]             drop_count_o,
    layer_argmax_collector_if.master res_o
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                state_q;
    logic [LAT-1:0]        vpipe_q;
    logic [NUM_IN*DW-1:0]  snap_q;
    logic [DW-1:0]         best_val_q, best_val_d;
    logic [IDXW-1:0]       best_idx_q, best_idx_d;
    logic                  best_tie_q, best_tie_d;
    logic [IDXW-1:0]       ptr_q;
    logic                  res_valid_q;
    logic [IDXW-1:0]       res_idx_q;
    logic [DW-1:0]         res_val_q;
    logic                  res_tie_q;
    logic [7:0]            drop_q;
    logic [DW-1:0]         elem;
    logic                  capture;
    logic                  last_elem;

    // Neuron nodes carry no valid, so the delay line marks when node_out belongs to a vector.
    assign capture   = vpipe_q[LAT-1];
    assign last_elem = (ptr_q == IDXW'(NUM_IN - 1));

    always_comb begin
        elem       = snap_q[int'(ptr_q)*DW +: DW];
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        best_tie_d = best_tie_q;
        if (elem > best_val_q) begin
            best_val_d = elem;
            best_idx_d = ptr_q;
            best_tie_d = 1'b0;
        end else if (elem == best_val_q) begin
            best_tie_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            vpipe_q     <= '0;
            snap_q      <= '0;
            best_val_q  <= '0;
            best_idx_q  <= '0;
            best_tie_q  <= 1'b0;
            ptr_q       <= '0;
            res_valid_q <= 1'b0;
            res_idx_q   <= '0;
            res_val_q   <= '0;
            res_tie_q   <= 1'b0;
            drop_q      <= '0;
        end else begin
            vpipe_q[0] <= src_valid_i;
            for (int k = 1; k < LAT; k++) begin
                vpipe_q[k] <= vpipe_q[k-1];
            end

            // Includes the handshake edge: state is still DONE when the capture is sampled.
            if (capture && (state_q != IDLE) && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end

            case (state_q)
                IDLE: begin
                    if (capture) begin
                        snap_q     <= node_out_i;
                        best_val_q <= node_out_i[DW-1:0];
                        best_idx_q <= '0;
                        best_tie_q <= 1'b0;
                        ptr_q      <= IDXW'(1);
                        if (NUM_IN == 1) begin
                            state_q     <= DONE;
                            res_valid_q <= 1'b1;
                            res_idx_q   <= '0;
                            res_val_q   <= node_out_i[DW-1:0];
                            res_tie_q   <= 1'b0;
                        end else begin
                            state_q <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    best_val_q <= best_val_d;
                    best_idx_q <= best_idx_d;
                    best_tie_q <= best_tie_d;
                    ptr_q      <= ptr_q + IDXW'(1);
                    if (last_elem) begin
                        state_q     <= DONE;
                        res_valid_q <= 1'b1;
                        res_idx_q   <= best_idx_d;
                        res_val_q   <= best_val_d;
                        res_tie_q   <= best_tie_d;
                    end
                end
                DONE: begin
                    if (res_o.res_ready) begin
                        state_q     <= IDLE;
                        res_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o          = (state_q != IDLE);
    assign drop_count_o    = drop_q;
    assign res_o.res_valid = res_valid_q;
    assign res_o.res_idx   = res_idx_q;
    assign res_o.res_val   = res_val_q;
    assign res_o.res_tie   = res_tie_q;
endmodule

// File: tb/tb_layer_argmax_collector.sv
// tb/tb_layer_argmax_collector.sv - self-checking bench for layer_argmax_collector
module tb_layer_argmax_collector;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        src_valid = 1'b0;
    logic [63:0] node_out = '0;
    logic        busy;
    logic [7:0]  drop_count;

    layer_argmax_collector_if #(.DW(8), .IDXW(4)) res_if ();

    layer_argmax_collector #(.NUM_IN(8), .DW(8), .IDXW(4), .LAT(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .src_valid_i  (src_valid),
        .node_out_i   (node_out),
        .busy_o       (busy),
        .drop_count_o (drop_count),
        .res_o        (res_if.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] vec;
        logic [3:0]  idx;
        logic [7:0]  val;
        logic        tie;
    } vec_t;

    typedef struct {
        logic [3:0] idx;
        logic [7:0] val;
        logic       tie;
        int         rise;
    } exp_t;

    vec_t tbl[5];
    exp_t sb[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   rises = 0;
    logic prev_rv = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: each rising res_valid must match the oldest expected result, including its latency.
    always @(negedge clk) begin
        if (res_if.res_valid && !prev_rv) begin
            exp_t e;
            rises++;
            if (sb.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                e = sb.pop_front();
                check("res_idx", int'(res_if.res_idx), int'(e.idx));
                check("res_val", int'(res_if.res_val), int'(e.val));
                check("res_tie", int'(res_if.res_tie), int'(e.tie));
                check("latency", cyc, e.rise);
            end
        end
        prev_rv = res_if.res_valid;
    end

    task automatic pulse(input logic [63:0] vec, input bit push, input logic [3:0] idx,
                         input logic [7:0] val, input logic tie, output int e);
        exp_t x;
        @(negedge clk);
        node_out  = vec;
        src_valid = 1'b1;
        e = cyc + 1;
        if (push) begin
            x.idx = idx; x.val = val; x.tie = tie; x.rise = e + 10;
            sb.push_back(x);
        end
        @(negedge clk);
        src_valid = 1'b0;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        check("drain", sb.size(), 0);
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, int'(res_if.res_valid), 0);
        check({tag, "_idx"}, int'(res_if.res_idx), 0);
        check({tag, "_val"}, int'(res_if.res_val), 0);
        check({tag, "_tie"}, int'(res_if.res_tie), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_drop"}, int'(drop_count), 0);
    endtask

    initial begin
        int e;
        int r0;
        tbl[0] = '{{8'd1, 8'd199, 8'd0, 8'd7, 8'd200, 8'd2, 8'd9, 8'd3}, 4'd3, 8'd200, 1'b0};
        tbl[1] = '{{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd40, 8'd40, 8'd5}, 4'd1, 8'd40, 1'b1};
        tbl[2] = '{64'd0, 4'd0, 8'd0, 1'b1};
        tbl[3] = '{{8'd255, 56'd0}, 4'd7, 8'd255, 1'b0};
        tbl[4] = '{{8'd255, 48'd0, 8'd254}, 4'd7, 8'd255, 1'b0};

        res_if.res_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            pulse(tbl[i].vec, 1'b1, tbl[i].idx, tbl[i].val, tbl[i].tie, e);
            repeat (3) @(negedge clk);
            check("busy_scan", int'(busy), 1);
            node_out = {$urandom(), $urandom()};
            wait_empty();
        end

        // Consumer stalls in DONE while a second vector's capture lands there.
        res_if.res_ready = 1'b0;
        pulse(tbl[0].vec, 1'b1, 4'd3, 8'd200, 1'b0, e);
        while (cyc < e + 8) @(negedge clk);
        node_out  = tbl[3].vec;
        src_valid = 1'b1;
        @(negedge clk);
        src_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            check("hold_valid", int'(res_if.res_valid), 1);
            check("hold_idx", int'(res_if.res_idx), 3);
            check("hold_val", int'(res_if.res_val), 200);
            check("hold_tie", int'(res_if.res_tie), 0);
            if (i == 5) res_if.res_ready = 1'b1;
            @(negedge clk);
        end
        check("hs_valid", int'(res_if.res_valid), 0);
        check("hs_busy", int'(busy), 0);
        check("hold_drop", int'(drop_count), 1);
        pulse({8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 1'b1, 4'd7, 8'd8, 1'b0, e);
        wait_empty();
        check("after_drop", int'(drop_count), 1);

        // Reset mid-scan with a second vector still in the delay line.
        r0 = rises;
        pulse(tbl[0].vec, 1'b0, 4'd0, 8'd0, 1'b0, e);
        while (cyc < e + 3) @(negedge clk);
        src_valid = 1'b1;
        @(negedge clk);
        src_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_zero("midreset");
        repeat (20) @(negedge clk);
        check("midreset_rises", rises - r0, 0);
        pulse(tbl[1].vec, 1'b1, 4'd1, 8'd40, 1'b1, e);
        wait_empty();
        check("midreset_drop", int'(drop_count), 0);

        // Flood with consecutive vectors while the first result is held.
        r0 = rises;
        res_if.res_ready = 1'b0;
        @(negedge clk);
        node_out  = tbl[3].vec;
        src_valid = 1'b1;
        begin
            exp_t x;
            x.idx = 4'd7; x.val = 8'd255; x.tie = 1'b0; x.rise = cyc + 11;
            sb.push_back(x);
        end
        repeat (300) @(negedge clk);
        src_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("sat_drop", int'(drop_count), 255);
        check("sat_valid", int'(res_if.res_valid), 1);
        res_if.res_ready = 1'b1;
        repeat (20) @(negedge clk);
        check("sat_rises", rises - r0, 1);
        check("sat_drain", sb.size(), 0);
        check("sat_busy", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
